// File: rtl/simon_ps2_pkg.sv
// Shared definitions for the Simon PS/2 keyboard front end: scancodes,
// receiver/decoder state encodings and the timeout counter sizing helper.
package simon_ps2_pkg;

    // Set-2 scancodes of the keys the game cares about
    localparam logic [7:0] SC_GREEN  = 8'h34;
    localparam logic [7:0] SC_RED    = 8'h2D;
    localparam logic [7:0] SC_YELLOW = 8'h35;
    localparam logic [7:0] SC_BLUE   = 8'h32;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // Prefix bytes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_NORM    = 2'd0,
        DEC_BRK     = 2'd1,
        DEC_EXT     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    // Bits needed for a counter that runs 0 .. cycles-1 (never narrower than 1)
    function automatic int tmo_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw PS/2 lines, detects falling
// clock edges and assembles 11-bit frames into bytes. A byte is offered
// for one cycle on rx_valid; any framing problem or a stalled frame gives
// a one-cycle rx_err instead.
module ps2_rx
    import simon_ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int              TW       = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall;

    rx_state_t     state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          rx_err_q;

    // Two-flop synchronizers; lines reset high (PS/2 idle) so no false edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall  = clk_prev_q & ~clk_s2_q;
    assign tmo_d = tmo_q + 1'b1;

    // Frame FSM plus stall timeout; an edge arriving on the timeout cycle wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RX_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;

            if (state_q == RX_IDLE || fall) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_d;
            end

            if (fall) begin
                case (state_q)
                    RX_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            rx_err_q  <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity_q <= dat_s2_q;
                        state_q  <= RX_STOP;
                    end
                    RX_STOP: begin
                        state_q <= RX_IDLE;
                        if (dat_s2_q && (^{shift_q, parity_q})) begin
                            rx_byte_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_err_q   <= 1'b1;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end else if (state_q != RX_IDLE && tmo_q == TMO_LAST) begin
                state_q  <= RX_IDLE;
                rx_err_q <= 1'b1;
            end
        end
    end

    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Keyboard front end for the Simon controller. Turns received scancodes
// into single-cycle key events, tracking break/extended prefixes and
// suppressing typematic repeats. Colour flags follow the last accepted make.
module ps2_key_decoder
    import simon_ps2_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] CODE_GREEN     = SC_GREEN,
    parameter logic [7:0] CODE_RED       = SC_RED,
    parameter logic [7:0] CODE_YELLOW    = SC_YELLOW,
    parameter logic [7:0] CODE_BLUE      = SC_BLUE,
    parameter logic [7:0] CODE_ENTER     = SC_ENTER
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic enter_pressed,
    output logic key_pressed,
    output logic key_released,
    output logic valid_input,
    output logic input_eq_green,
    output logic input_eq_red,
    output logic input_eq_yellow,
    output logic input_eq_blue,
    output logic frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    dec_state_t dec_q;
    logic [7:0] code_q;
    logic       held_q;
    logic       enter_held_q;
    logic       enter_pressed_q;
    logic       key_pressed_q;
    logic       key_released_q;
    logic       valid_q;
    logic       eq_green_q, eq_red_q, eq_yellow_q, eq_blue_q;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    // Prefix tracking, key latch and event pulses; colour flags refresh with key_pressed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_q           <= DEC_NORM;
            code_q          <= 8'h00;
            held_q          <= 1'b0;
            enter_held_q    <= 1'b0;
            enter_pressed_q <= 1'b0;
            key_pressed_q   <= 1'b0;
            key_released_q  <= 1'b0;
            valid_q         <= 1'b0;
            eq_green_q      <= 1'b0;
            eq_red_q        <= 1'b0;
            eq_yellow_q     <= 1'b0;
            eq_blue_q       <= 1'b0;
        end else begin
            enter_pressed_q <= 1'b0;
            key_pressed_q   <= 1'b0;
            key_released_q  <= 1'b0;

            if (rx_valid) begin
                case (dec_q)
                    DEC_NORM: begin
                        if (rx_byte == SC_BREAK) begin
                            dec_q <= DEC_BRK;
                        end else if (rx_byte == SC_EXT) begin
                            dec_q <= DEC_EXT;
                        end else if (rx_byte == CODE_ENTER) begin
                            if (!enter_held_q) begin
                                enter_held_q    <= 1'b1;
                                enter_pressed_q <= 1'b1;
                            end
                        end else if (!held_q) begin
                            code_q        <= rx_byte;
                            held_q        <= 1'b1;
                            key_pressed_q <= 1'b1;
                            eq_green_q    <= (rx_byte == CODE_GREEN);
                            eq_red_q      <= (rx_byte == CODE_RED);
                            eq_yellow_q   <= (rx_byte == CODE_YELLOW);
                            eq_blue_q     <= (rx_byte == CODE_BLUE);
                            valid_q       <= (rx_byte == CODE_GREEN)  ||
                                             (rx_byte == CODE_RED)    ||
                                             (rx_byte == CODE_YELLOW) ||
                                             (rx_byte == CODE_BLUE);
                        end
                    end
                    DEC_BRK: begin
                        dec_q <= DEC_NORM;
                        if (rx_byte == CODE_ENTER) begin
                            enter_held_q <= 1'b0;
                        end else if (held_q && rx_byte == code_q) begin
                            held_q         <= 1'b0;
                            key_released_q <= 1'b1;
                        end
                    end
                    DEC_EXT: begin
                        dec_q <= (rx_byte == SC_BREAK) ? DEC_EXT_BRK : DEC_NORM;
                    end
                    DEC_EXT_BRK: begin
                        dec_q <= DEC_NORM;
                    end
                    default: dec_q <= DEC_NORM;
                endcase
            end
        end
    end

    assign enter_pressed   = enter_pressed_q;
    assign key_pressed     = key_pressed_q;
    assign key_released    = key_released_q;
    assign valid_input     = valid_q;
    assign input_eq_green  = eq_green_q;
    assign input_eq_red    = eq_red_q;
    assign input_eq_yellow = eq_yellow_q;
    assign input_eq_blue   = eq_blue_q;
    assign frame_err       = rx_err;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream input stage for the Simon game controller.
- Receives PS/2 set-2 scancodes from the keyboard and tracks make/break and extended prefixes.
- Produces the controller's key event inputs: enter_pressed, key_pressed, key_released, valid_input and input_eq_green/red/yellow/blue.
- Events are clean single-cycle pulses, with typematic repeats suppressed.

Parameters:
- TIMEOUT_CYCLES, 50000, idle clk cycles between PS/2 falling edges mid-frame before the frame is aborted (1 ms at 50 MHz).
- CODE_GREEN, 8'h34, scancode of the green key (G).
- CODE_RED, 8'h2D, scancode of the red key (R).
- CODE_YELLOW, 8'h35, scancode of the yellow key (Y).
- CODE_BLUE, 8'h32, scancode of the blue key (B).
- CODE_ENTER, 8'h5A, scancode of Enter.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- enter_pressed  out  1  one-cycle pulse on the first Enter make.
- key_pressed  out  1  one-cycle pulse on the first make of a non-Enter key.
- key_released  out  1  one-cycle pulse on the break of the currently held key.
- valid_input  out  1  level; latched key code is one of the four colour codes.
- input_eq_green  out  1  level; latched code == CODE_GREEN.
- input_eq_red  out  1  level; latched code == CODE_RED.
- input_eq_yellow  out  1  level; latched code == CODE_YELLOW.
- input_eq_blue  out  1  level; latched code == CODE_BLUE.
- frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error.

Behaviour:
- Reset (async): all outputs 0. Latched code = 8'h00, held flag = 0, enter_held = 0. Receiver and decoder return to idle; a frame in progress is discarded.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-flop synchronizer. A falling edge is (prev sync clk = 1, current = 0), giving one cycle per edge.
- Receiver FSM: RX_IDLE -> RX_DATA -> RX_PARITY -> RX_STOP -> RX_IDLE. Transitions happen only on falling edges.
- RX_IDLE: data = 0 goes to RX_DATA with bit count = 0. Data = 1 is a start error: frame_err pulses and the FSM stays idle.
- RX_DATA: shifts 8 bits, LSB first, then goes to RX_PARITY.
- RX_PARITY: stores the parity bit.
- RX_STOP: the byte is valid only if stop = 1 and odd parity holds over 8 data bits + parity. Otherwise frame_err pulses and the byte is dropped.
- The timeout counter runs while not in RX_IDLE and clears on every falling edge.
  - Reaching TIMEOUT_CYCLES-1: return to RX_IDLE and pulse frame_err.
  - A falling edge in the same cycle as the timeout wins; no abort.
- Internal rx_valid is registered in the cycle after the stop-bit edge is detected. Decoder outputs are registered one cycle after rx_valid. Total latency from stop-edge detection to an event pulse is 2 cycles.
- Decoder FSM: DEC_NORM, DEC_BRK, DEC_EXT, DEC_EXT_BRK.
  - DEC_NORM: F0 -> DEC_BRK; E0 -> DEC_EXT; any other byte is a make code.
  - DEC_BRK: byte is a break code -> DEC_NORM.
  - DEC_EXT: F0 -> DEC_EXT_BRK; any other byte is ignored -> DEC_NORM.
  - DEC_EXT_BRK: byte is ignored -> DEC_NORM.
  - All extended-key traffic is ignored.
- Make CODE_ENTER:
  - enter_held = 0: pulse enter_pressed and set enter_held.
  - Otherwise (typematic repeat): no event.
- Break CODE_ENTER: clear enter_held.
- Make of any other code:
  - held = 0: latch the code, set held, pulse key_pressed.
  - held = 1 (repeat, or a second key pressed): no event; latch unchanged.
- Break of the latched code with held = 1: clear held, pulse key_released.
- Break of any other code: ignored.
- valid_input and input_eq_* are decoded from a registered copy of the latch. The copy updates on the same edge as the key_pressed pulse, so both are valid in the pulse cycle. They hold until the next accepted make.
- Non-colour keys pulse key_pressed with valid_input = 0. This matches the controller's key_pressed & valid_input gating.
- At most one event pulse per received byte. frame_err never coincides with a decoder pulse from the same frame.

Decomposition:
- Shared package simon_ps2_pkg holds:
  - scancode constants (colour codes, Enter, 8'hF0 break prefix, 8'hE0 extended prefix);
  - receiver and decoder state enums;
  - timeout counter width function.
- One sub-module, ps2_rx: synchronizers, edge detect, receiver FSM, timeout. It outputs rx_byte[7:0], rx_valid and rx_err.
- The top level holds the decoder FSM and key tracking.

Test Plan:
- Frame 8'h34 (start 0, LSB first, parity 0, stop 1) -> key_pressed 1 cycle, valid_input = 1, input_eq_green = 1 in the same cycle.
- Frames 34, 34, 34 (typematic), then F0 34 -> exactly one key_pressed, then one key_released; input_eq_green stays 1 after the release.
- Frame 5A, repeat 5A, then F0 5A -> exactly one enter_pressed; key_pressed never asserts.
- 8'h2D with the parity bit flipped -> frame_err pulse, no key_pressed, latch unchanged.
- Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES, then send 8'h32 -> one frame_err, then key_pressed with input_eq_blue = 1.
- Held 2D, then make 35, then E0 F0 2D, then F0 2D -> no event on 35 or on the extended break; key_released only on the final F0 2D. Asserting reset mid-frame clears all outputs asynchronously.
